alu_exec_ctrl: RTL and testbench

Multi-cycle control sequencer for the register-to-register ALU execute phase. It accepts one decoded ALU instruction (opcode plus ra/rb/rc register fields) and drives the bus, register-file, Y and Z strobes through the load-Y, execute and write-back control steps around the shared ALU. It also flags illegal opcodes and keeps a saturating count of completed operations. It sits between the instruction decoder and the bus/register datapath.

---
 rtl/alu_exec_ctrl.sv | 125 ++++++++++++
 tb/tb_alu_exec_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_ctrl.sv
// Execute-phase sequencer for register-to-register ALU ops.
// Walks LDY/EXE/WB around the shared ALU and counts completed ops.
module alu_exec_ctrl (
  input  logic       clock,
  input  logic       clear,
  input  logic       start,
  input  logic [4:0] opcode,
  input  logic [3:0] ra,
  input  logic [3:0] rb,
  input  logic [3:0] rc,
  output logic       ready,
  output logic       done,
  output logic       err,
  output logic       reg_out_en,
  output logic [3:0] reg_out_sel,
  output logic       reg_in_en,
  output logic [3:0] reg_in_sel,
  output logic       y_in,
  output logic       z_in,
  output logic       zlow_out,
  output logic [4:0] alu_select,
  output logic [15:0] op_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDY,
    S_EXE,
    S_WB,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [4:0]  op_q;
  logic [3:0]  ra_q;
  logic [3:0]  rb_q;
  logic [3:0]  rc_q;
  logic        err_q;
  logic [15:0] cnt_q;

  function automatic logic is_unary(input logic [4:0] op);
    return (op == 5'b01110) || (op == 5'b01111);
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    return (op <= 5'b01000) || is_unary(op);
  endfunction

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q  <= opcode;
            ra_q  <= ra;
            rb_q  <= rb;
            rc_q  <= rc;
            err_q <= !is_legal(opcode);
            state_q <= is_legal(opcode) ? S_LDY : S_DONE;
          end
        end
        S_LDY: state_q <= S_EXE;
        S_EXE: state_q <= S_WB;
        S_WB: begin
          state_q <= S_DONE;
          // count lands together with the done pulse
          if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ready       = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    reg_out_en  = 1'b0;
    reg_out_sel = '0;
    reg_in_en   = 1'b0;
    reg_in_sel  = '0;
    y_in        = 1'b0;
    z_in        = 1'b0;
    zlow_out    = 1'b0;
    alu_select  = '0;
    unique case (state_q)
      S_IDLE: ready = 1'b1;
      S_LDY: begin
        reg_out_en  = 1'b1;
        reg_out_sel = rb_q;
        y_in        = 1'b1;
      end
      S_EXE: begin
        alu_select = op_q;
        z_in       = 1'b1;
        if (!is_unary(op_q)) begin
          reg_out_en  = 1'b1;
          reg_out_sel = rc_q;
        end
      end
      S_WB: begin
        zlow_out   = 1'b1;
        reg_in_en  = 1'b1;
        reg_in_sel = ra_q;
      end
      S_DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

  assign op_count = cnt_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl: vector table plus
// busy-start, mid-op clear and saturation sequences.
module tb_alu_exec_ctrl;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        ready, done, err;
  logic        reg_out_en, reg_in_en;
  logic [3:0]  reg_out_sel, reg_in_sel;
  logic        y_in, z_in, zlow_out;
  logic [4:0]  alu_select;
  logic [15:0] op_count;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_cnt;

  always #5 clock = ~clock;

  alu_exec_ctrl dut (
    .clock(clock), .clear(clear), .start(start),
    .opcode(opcode), .ra(ra), .rb(rb), .rc(rc),
    .ready(ready), .done(done), .err(err),
    .reg_out_en(reg_out_en), .reg_out_sel(reg_out_sel),
    .reg_in_en(reg_in_en), .reg_in_sel(reg_in_sel),
    .y_in(y_in), .z_in(z_in), .zlow_out(zlow_out),
    .alu_select(alu_select), .op_count(op_count)
  );

  logic [20:0] obs;
  assign obs = {ready, done, err, reg_out_en, reg_out_sel,
                reg_in_en, reg_in_sel, y_in, z_in, zlow_out,
                alu_select};

  typedef struct {
    string      nm;
    logic [4:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       legal;
    logic       unary;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [20:0] mk(
    input logic rdy, input logic dn, input logic er,
    input logic roe, input logic [3:0] rsel,
    input logic rie, input logic [3:0] isel,
    input logic y, input logic z, input logic zl,
    input logic [4:0] alu);
    return {rdy, dn, er, roe, rsel, rie, isel, y, z, zl, alu};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    @(negedge clock);
    chk({v.nm, " ready"}, ready, 1);
    start = 1'b1; opcode = v.op;
    ra = v.ra; rb = v.rb; rc = v.rc;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    opcode = 5'h1F; ra = 4'hF; rb = 4'hF; rc = 4'hF;
    if (v.legal) begin
      chk({v.nm, " ldy"}, obs,
          mk(0,0,0, 1,v.rb, 0,0, 1,0,0, 0));
      @(negedge clock);
      chk({v.nm, " exe"}, obs,
          mk(0,0,0, !v.unary, v.unary ? 4'd0 : v.rc,
             0,0, 0,1,0, v.op));
      @(negedge clock);
      chk({v.nm, " wb"}, obs,
          mk(0,0,0, 0,0, 1,v.ra, 0,0,1, 0));
      @(negedge clock);
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      chk({v.nm, " done"}, obs,
          mk(0,1,0, 0,0, 0,0, 0,0,0, 0));
      chk({v.nm, " count"}, op_count, exp_cnt);
    end else begin
      chk({v.nm, " done_err"}, obs,
          mk(0,1,1, 0,0, 0,0, 0,0,0, 0));
    end
    @(negedge clock);
    chk({v.nm, " idle"}, obs, mk(1,0,0, 0,0, 0,0, 0,0,0, 0));
    chk({v.nm, " idle_cnt"}, op_count, exp_cnt);
  endtask

  initial begin
    logic [15:0] ymask, dmask;
    logic        seen;
    vecs[0]  = '{"add",   5'b00000, 4'd3, 4'd1, 4'd2, 1, 0};
    vecs[1]  = '{"sub",   5'b00001, 4'd7, 4'd8, 4'd9, 1, 0};
    vecs[2]  = '{"shra",  5'b00101, 4'd0, 4'd15, 4'd6, 1, 0};
    vecs[3]  = '{"rol",   5'b01000, 4'd12, 4'd10, 4'd11, 1, 0};
    vecs[4]  = '{"neg",   5'b01110, 4'd2, 4'd9, 4'd13, 1, 1};
    vecs[5]  = '{"not",   5'b01111, 4'd5, 4'd4, 4'd7, 1, 1};
    vecs[6]  = '{"alias", 5'b00010, 4'd6, 4'd6, 4'd6, 1, 0};
    vecs[7]  = '{"ill0a", 5'b01010, 4'd1, 4'd2, 4'd3, 0, 0};
    vecs[8]  = '{"ill09", 5'b01001, 4'd1, 4'd2, 4'd3, 0, 0};
    vecs[9]  = '{"ill0d", 5'b01101, 4'd1, 4'd2, 4'd3, 0, 0};
    vecs[10] = '{"ill10", 5'b10000, 4'd1, 4'd2, 4'd3, 0, 0};
    vecs[11] = '{"ill1f", 5'b11111, 4'd1, 4'd2, 4'd3, 0, 0};

    clear = 1'b1; start = 1'b0;
    opcode = '0; ra = '0; rb = '0; rc = '0;
    exp_cnt = '0;
    repeat (2) @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    chk("reset obs", obs, mk(1,0,0, 0,0, 0,0, 0,0,0, 0));
    chk("reset cnt", op_count, 0);

    for (int i = 0; i < 12; i++) run_op(vecs[i]);

    // start held high: accepts at N, N+5, N+10 only
    @(negedge clock);
    start = 1'b1; opcode = 5'b00011;
    ra = 4'd1; rb = 4'd2; rc = 4'd3;
    ymask = '0; dmask = '0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      ymask[k] = y_in;
      dmask[k] = done;
      if (k == 11) start = 1'b0;
    end
    chk("busy y_in", ymask, 16'h0842);
    chk("busy done", dmask, 16'h4210);
    exp_cnt = exp_cnt + 16'd3;
    chk("busy cnt", op_count, exp_cnt);
    @(negedge clock);
    chk("busy idle", obs, mk(1,0,0, 0,0, 0,0, 0,0,0, 0));

    // clear in cycle N+2 aborts the op
    start = 1'b1; opcode = 5'b00000;
    ra = 4'd9; rb = 4'd1; rc = 4'd2;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk("abort exe", z_in, 1);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    exp_cnt = '0;
    chk("abort obs", obs, mk(1,0,0, 0,0, 0,0, 0,0,0, 0));
    chk("abort cnt", op_count, 0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clock);
      seen = seen | done | reg_in_en | err;
    end
    chk("abort quiet", seen, 0);

    // clear wins over a simultaneous start
    start = 1'b1; clear = 1'b1;
    @(negedge clock);
    start = 1'b0; clear = 1'b0;
    chk("clr_vs_start", obs, mk(1,0,0, 0,0, 0,0, 0,0,0, 0));

    // saturation
    force dut.cnt_q = 16'hFFFE;
    #1 release dut.cnt_q;
    exp_cnt = 16'hFFFE;
    run_op(vecs[0]);
    chk("sat max", op_count, 16'hFFFF);
    run_op(vecs[5]);
    chk("sat hold", op_count, 16'hFFFF);
    run_op(vecs[7]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
